seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width in bits.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: CLK  input  1  clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  synchronous active-high reset.
REQ-005 Port: START  input  1  request to begin a division; sampled each rising edge.
REQ-006 Port: DIVIDEND  input  WIDTH  unsigned dividend; captured when START is accepted.
REQ-007 Port: DIVISOR  input  WIDTH  unsigned divisor; captured when START is accepted.
REQ-008 Port: QUOT  output  WIDTH  unsigned quotient.
REQ-009 Port: REM  output  WIDTH  unsigned remainder.
REQ-010 Port: BUSY  output  1  high while a division is in progress.
REQ-011 Port: DONE  output  1  one-cycle pulse; QUOT/REM/DIV_BY_ZERO are valid.
REQ-012 Port: DIV_BY_ZERO  output  1  high with DONE when the captured divisor was 0.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and FIN.
REQ-014 START SHALL be accepted only in IDLE or FIN; START in RUN SHALL be ignored, with no effect on state or operands.
REQ-015 On an accepted START with DIVISOR != 0, the block SHALL capture the operands, clear the iteration counter, clear the partial remainder and enter RUN.
REQ-016 Each RUN cycle SHALL perform one restoring step:
- shift {remainder, quotient} left by 1, moving the dividend MSB into the remainder LSB;
- form trial = remainder - divisor at WIDTH+1 bits;
- if trial >= 0: remainder = trial, quotient LSB = 1;
- otherwise: remainder unchanged, quotient LSB = 0.
REQ-017 RUN SHALL last exactly WIDTH cycles, then transition to FIN.
REQ-018 Latency: DONE SHALL be high in the (WIDTH+1)th cycle after the START-accept edge (cycle 17 for WIDTH=16).
REQ-019 BUSY SHALL be high in every RUN cycle and low in IDLE and FIN.
REQ-020 In FIN, DONE SHALL be high for exactly one cycle, and the FSM SHALL go to IDLE unless START is accepted in that cycle.
REQ-021 On an accepted START with DIVISOR == 0, the block SHALL skip RUN and enter FIN on the next edge with:
- QUOT = all ones;
- REM = DIVIDEND;
- DIV_BY_ZERO = 1.
REQ-022 QUOT, REM and DIV_BY_ZERO SHALL hold their last results from FIN until the next accepted START.
REQ-023 DIV_BY_ZERO SHALL clear on the next accepted START.
REQ-024 During RUN, QUOT/REM SHALL show intermediate values, which are not valid until DONE.
REQ-025 All arithmetic SHALL be unsigned, with no overflow possible: QUOT <= DIVIDEND and REM < DIVISOR.
REQ-026 Divide result for DIVISOR > DIVIDEND: QUOT = 0, REM = DIVIDEND.

Reset
REQ-027 RST high at a rising edge SHALL force, overriding START and any operation in progress:
- state IDLE;
- QUOT = 0, REM = 0;
- BUSY = 0, DONE = 0, DIV_BY_ZERO = 0;
- iteration counter = 0.
REQ-028 An operation interrupted by RST SHALL be abandoned with no DONE pulse.
REQ-029 After reset, a new START SHALL be accepted on the first edge with RST low.

Structure
REQ-030 The state encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the default WIDTH SHALL be defined in the shared ALU constants header, alu_defs.
REQ-031 One combinational sub-module, div_step, SHALL implement a single restoring step.
- Inputs: remainder, quotient, divisor.
- Outputs: next remainder, next quotient.
- It SHALL reuse the 16-bit ADDER with divisor complement and carry-in for the trial subtraction.
REQ-032 The iteration counter SHALL be clog2(WIDTH)+1 bits wide.

Verification
REQ-033 DIVIDEND=100, DIVISOR=7, START one cycle -> BUSY for 16 cycles, then DONE at cycle 17 with QUOT=14, REM=2, DIV_BY_ZERO=0.
REQ-034 DIVIDEND=500, DIVISOR=1000 -> QUOT=0, REM=500; separately, DIVIDEND=65535, DIVISOR=1 -> QUOT=65535, REM=0.
REQ-035 DIVIDEND=1234, DIVISOR=0 -> DONE on the cycle after accept, with QUOT=16'hFFFF, REM=1234, DIV_BY_ZERO=1 and BUSY never high.
REQ-036 100/7 started, then START with 9/3 asserted at cycle 5 -> the second request is ignored and results are QUOT=14, REM=2.
REQ-037 100/7 started, RST at cycle 8 -> all outputs 0 next cycle and no DONE pulse; then 9/3 started -> QUOT=3, REM=0 at cycle 17.
REQ-038 START held high across FIN with 200/10 loaded -> back-to-back operations with a DONE at cycle 17 and a second DONE 17 cycles later, second result QUOT=20, REM=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared ALU constants for the sequential divider: default operand width,
// FSM state encodings and the iteration-counter sizing helper.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  // Counter must be able to hold WIDTH itself, hence one bit more than clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider; the master drives operands
// and START, the slave (the divider) returns quotient, remainder and status.
interface seq_divider_if import seq_divider_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quot, rem, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quot, rem, busy, done, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift {rem, quot} left, try to
// subtract the divisor from the widened remainder, keep the result if no borrow.
module seq_divider_div_step import seq_divider_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  localparam int AW = WIDTH + 1;

  // Plain adder with carry-in; subtraction is a + ~b + 1 and carry-out means no borrow.
  function automatic logic [AW:0] adder(input logic [AW-1:0] a,
                                        input logic [AW-1:0] b,
                                        input logic          cin);
    return {1'b0, a} + {1'b0, b} + {{AW{1'b0}}, cin};
  endfunction

  logic [AW-1:0]    rem_sh_s;
  logic [WIDTH-1:0] quot_sh_s;
  logic [AW:0]      sum_s;
  logic             no_borrow_s;
  logic             trial_top_unused_s;

  // The shifted remainder can reach 2*divisor-1, so the trial runs at WIDTH+1 bits.
  always_comb begin
    rem_sh_s           = {rem_i, quot_i[WIDTH-1]};
    quot_sh_s          = {quot_i[WIDTH-2:0], 1'b0};
    sum_s              = adder(rem_sh_s, ~{1'b0, divisor_i}, 1'b1);
    no_borrow_s        = sum_s[AW];
    trial_top_unused_s = sum_s[WIDTH];
    if (no_borrow_s) begin
      rem_o  = sum_s[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh_s[WIDTH-1:0];
      quot_o = quot_sh_s;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle,
// a one-cycle DONE in FIN, and a short-cut to FIN on a zero divisor.
module seq_divider import seq_divider_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic          clk_i,
  input logic          rst_i,
  seq_divider_if.slave div_bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quot_s;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem_s),
    .quot_o    (step_quot_s)
  );

  // Next-state and datapath update; START is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (div_bus.start) begin
          cnt_d = {CNT_W{1'b0}};
          if (div_bus.divisor == {WIDTH{1'b0}}) begin
            state_d = ST_FIN;
            quot_d  = {WIDTH{1'b1}};
            rem_d   = div_bus.dividend;
            dvsr_d  = {WIDTH{1'b0}};
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            quot_d  = div_bus.dividend;
            rem_d   = {WIDTH{1'b0}};
            dvsr_d  = div_bus.divisor;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        quot_d = step_quot_s;
        rem_d  = step_rem_s;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_FIN);
  end

  // State and result registers with synchronous reset taking priority over START.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dvsr_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_bus.quot        = quot_q;
  assign div_bus.rem         = rem_q;
  assign div_bus.busy        = busy_q;
  assign div_bus.done        = done_q;
  assign div_bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients/remainders, latency,
// divide-by-zero, ignored START in RUN, mid-run reset and back-to-back operation.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  seq_divider_if #(.WIDTH(16)) dif ();

  seq_divider #(.WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .div_bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse START for one edge, wait (bounded) for DONE, then check the results.
  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                        input logic [15:0] exp_q, input logic [15:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int lat;
    int busy_n;
    bit seen;
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    tick();
    dif.start = 1'b0;
    lat    = 1;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && lat <= 40) begin
      if (dif.busy) busy_n++;
      if (dif.done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
    check({tag, "_quot"}, dif.quot, exp_q);
    check({tag, "_rem"}, dif.rem, exp_r);
    check({tag, "_dbz"}, dif.div_by_zero, exp_dbz);
    tick();
    check({tag, "_done_pulse"}, dif.done, 1'b0);
  endtask

  initial begin
    int lat;
    int done_n;
    bit seen;
    n_cmp  = 0;
    n_fail = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = 16'd0;
    dif.divisor  = 16'd0;
    repeat (3) tick();
    check("rst_quot", dif.quot, 16'd0);
    check("rst_rem", dif.rem, 16'd0);
    check("rst_busy", dif.busy, 1'b0);
    check("rst_done", dif.done, 1'b0);
    check("rst_dbz", dif.div_by_zero, 1'b0);
    rst = 1'b0;

    // First edge with reset low already accepts START.
    run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run_op("d500_1000", 16'd500, 16'd1000, 16'd0, 16'd500, 1'b0, 17);
    run_op("d65535_1", 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 17);
    run_op("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17);
    run_op("d65535_65535", 16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0, 17);
    run_op("dbz_1234", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);

    repeat (3) tick();
    check("hold_quot", dif.quot, 16'hFFFF);
    check("hold_rem", dif.rem, 16'd1234);
    check("hold_dbz", dif.div_by_zero, 1'b1);

    // 100/7 with a 9/3 START arriving at cycle 5 that must be ignored.
    dif.start    = 1'b1;
    dif.dividend = 16'd100;
    dif.divisor  = 16'd7;
    tick();
    dif.start = 1'b0;
    check("ign_dbz_clear", dif.div_by_zero, 1'b0);
    check("ign_busy_c1", dif.busy, 1'b1);
    repeat (4) tick();
    dif.start    = 1'b1;
    dif.dividend = 16'd9;
    dif.divisor  = 16'd3;
    tick();
    dif.start = 1'b0;
    check("ign_busy_c6", dif.busy, 1'b1);
    repeat (10) tick();
    check("ign_done_c16", dif.done, 1'b0);
    tick();
    check("ign_done_c17", dif.done, 1'b1);
    check("ign_quot", dif.quot, 16'd14);
    check("ign_rem", dif.rem, 16'd2);
    tick();
    check("ign_after_done", dif.done, 1'b0);

    // 100/7 abandoned by reset at cycle 8.
    dif.start    = 1'b1;
    dif.dividend = 16'd100;
    dif.divisor  = 16'd7;
    tick();
    dif.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("mrst_quot", dif.quot, 16'd0);
    check("mrst_rem", dif.rem, 16'd0);
    check("mrst_busy", dif.busy, 1'b0);
    check("mrst_done", dif.done, 1'b0);
    check("mrst_dbz", dif.div_by_zero, 1'b0);
    rst    = 1'b0;
    done_n = 0;
    repeat (20) begin
      tick();
      if (dif.done) done_n++;
    end
    check("mrst_no_done", done_n, 0);
    run_op("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17);

    // START held high with 200/10: second operation accepted in FIN.
    dif.start    = 1'b1;
    dif.dividend = 16'd200;
    dif.divisor  = 16'd10;
    tick();
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (dif.done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check("b2b_lat1", lat, 17);
    check("b2b_quot1", dif.quot, 16'd20);
    check("b2b_rem1", dif.rem, 16'd0);
    tick();
    check("b2b_busy_restart", dif.busy, 1'b1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (dif.done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    dif.start = 1'b0;
    check("b2b_lat2", lat, 17);
    check("b2b_quot2", dif.quot, 16'd20);
    check("b2b_rem2", dif.rem, 16'd0);
    tick();
    check("b2b_idle_done", dif.done, 1'b0);
    check("b2b_idle_busy", dif.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
